// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM-stage load/store initiator.
// Optional MEM_ACCESS_ALIGN_CHECK_EN build flag is consumed by mem_access_unit.
package mem_access_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned LANE_BITS  = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_e;

  // The unused size code 2'b11 behaves exactly like a word access.
  function automatic size_e decodeSize(input logic [1:0] rawSize);
    case (rawSize)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling shared by loads and sub-word stores:
// extracts and extends the addressed lane of a read word, and merges
// store data into that lane while keeping every other bit.
module lsu_lane_align
  import mem_access_pkg::*;
(
  input  size_e                accessSize_i,
  input  logic                 signExt_i,
  input  logic [LANE_BITS-1:0] lane_i,
  input  logic [31:0]          readWord_i,
  input  logic [31:0]          storeData_i,
  output logic [31:0]          loadData_o,
  output logic [31:0]          mergedWord_o
);

  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  // Half accesses select their lane by the upper lane bit only.
  assign laneByte = readWord_i[{lane_i, 3'b000} +: 8];
  assign laneHalf = readWord_i[{lane_i[1], 4'b0000} +: 16];

  // Extend the extracted lane for loads and splice store data into the read word.
  always_comb begin
    loadData_o   = readWord_i;
    mergedWord_o = readWord_i;
    case (accessSize_i)
      SZ_BYTE: begin
        loadData_o = {{24{signExt_i & laneByte[7]}}, laneByte};
        mergedWord_o[{lane_i, 3'b000} +: 8] = storeData_i[7:0];
      end
      SZ_HALF: begin
        loadData_o = {{16{signExt_i & laneHalf[15]}}, laneHalf};
        mergedWord_o[{lane_i[1], 4'b0000} +: 16] = storeData_i[15:0];
      end
      default: begin
        loadData_o   = readWord_i;
        mergedWord_o = storeData_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and a word-indexed data memory.
// Sub-word stores are done as read-modify-write through lsu_lane_align.
// Define MEM_ACCESS_ALIGN_CHECK_EN to fault misaligned or out-of-range requests.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  size_e             size_q, size_d;
  logic              signed_q, signed_d;
  logic              write_q, write_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  size_e             reqSize;
  logic [31:0]       loadData;
  logic [31:0]       mergedWord;

  assign reqSize = decodeSize(req_size);

  // Memory strobes come straight from the state so an async reset drops them at once.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign mem_read   = (state_q == READ);
  assign mem_write  = (state_q == WRITE);
  assign mem_addr   = addr_q >> LANE_BITS;
  assign mem_wdata  = wdata_q;
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  logic err_q, err_d;
  logic reqFault;

  assign reqFault = ((reqSize == SZ_HALF) && req_addr[0]) ||
                    ((reqSize == SZ_WORD) && (req_addr[LANE_BITS-1:0] != '0)) ||
                    ((req_addr >> LANE_BITS) >= ADDR_W'(DEPTH_WORDS));
  assign resp_err = resp_valid & err_q;
`else
  assign resp_err = 1'b0;
`endif

  lsu_lane_align u_lane_align (
    .accessSize_i (size_q),
    .signExt_i    (signed_q),
    .lane_i       (addr_q[LANE_BITS-1:0]),
    .readWord_i   (mem_rdata),
    .storeData_i  (wdata_q),
    .loadData_o   (loadData),
    .mergedWord_o (mergedWord)
  );

  // Next-state logic: capture the request on accept, then sequence READ/WRITE/RESP.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    signed_d = signed_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          size_d   = reqSize;
          signed_d = req_signed;
          write_d  = req_write;
          wdata_d  = req_wdata;
          rdata_d  = 32'h0;
          if (req_write && (reqSize == SZ_WORD)) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
          err_d = reqFault;
          if (reqFault) begin
            state_d = RESP;
          end
`endif
        end
      end
      READ: begin
        if (write_q) begin
          wdata_d = mergedWord;
          state_d = WRITE;
        end else begin
          rdata_d = loadData;
          state_d = RESP;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and request registers; reset abandons any request in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a 16-word data memory.
// Honours MEM_ACCESS_ALIGN_CHECK_EN in its reference model.
module tb_mem_access_unit;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } expect_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] memArray [DEPTH];
  logic [31:0] refMem   [DEPTH];
  expect_t     expQ[$];
  int          checks;
  int          errors;
  logic [31:0] expMemAddr;
  logic        noMemAccess;
  logic [31:0] lastRdata;

  mem_access_unit #(.ADDR_W(32), .DEPTH_WORDS(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_rdata = memArray[mem_addr[3:0]];

  // Data memory commits on the falling edge of a write cycle.
  always @(negedge clk) begin
    if (mem_write) memArray[mem_addr[3:0]] <= mem_wdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  function automatic bit modelFault(input logic [1:0] sz, input logic [31:0] addr);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    if (sz == 2'b01 && (addr % 2) != 0) return 1'b1;
    if ((sz == 2'b10 || sz == 2'b11) && (addr % 4) != 0) return 1'b1;
    if ((addr / 4) >= DEPTH) return 1'b1;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] modelLoad(input logic [1:0] sz, input logic sgn, input logic [31:0] addr);
    logic [31:0] w;
    logic [31:0] v;
    int          sh;
    w = refMem[addr / 4];
    if (sz == 2'b00) begin
      sh = (addr % 4) * 8;
      v  = (w >> sh) & 32'hFF;
      if (sgn && v >= 128) v = v - 256;
    end else if (sz == 2'b01) begin
      sh = ((addr / 2) % 2) * 16;
      v  = (w >> sh) & 32'hFFFF;
      if (sgn && v >= 32768) v = v - 65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic modelStore(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] w;
    int          sh;
    w = refMem[addr / 4];
    if (sz == 2'b00) begin
      sh = (addr % 4) * 8;
      w  = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
    end else if (sz == 2'b01) begin
      sh = ((addr / 2) % 2) * 16;
      w  = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
    end else begin
      w = wd;
    end
    refMem[addr / 4] = w;
  endtask

  // Issue one request, predict its response and check accept/response timing.
  task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wd, input bit holdHigh);
    expect_t e;
    int      expLat;
    int      lat;
    bit      fault;
    fault = modelFault(sz, addr);
    if (fault) begin
      e = '{rdata: 32'h0, err: 1'b1};
      expLat = 1;
    end else if (!wr) begin
      e = '{rdata: modelLoad(sz, sgn, addr), err: 1'b0};
      expLat = 2;
    end else begin
      modelStore(sz, addr, wd);
      e = '{rdata: 32'h0, err: 1'b0};
      expLat = (sz == 2'b00 || sz == 2'b01) ? 3 : 2;
    end
    expQ.push_back(e);
    @(negedge clk);
    expMemAddr  = addr / 4;
    noMemAccess = fault;
    req_write   = wr;
    req_size    = sz;
    req_signed  = sgn;
    req_addr    = addr;
    req_wdata   = wd;
    req_valid   = 1'b1;
    checkOutput("ready_before_accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    if (!holdHigh) req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_size  = 2'($urandom);
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checkOutput("ready_busy", 32'(req_ready), 32'd0);
      if (resp_valid) begin
        lat = k;
        break;
      end
    end
    checkOutput("latency", 32'(lat), 32'(expLat));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("ready_idle", 32'(req_ready), 32'd1);
    noMemAccess = 1'b0;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
    checkOutput("rst_mem_read", 32'(mem_read), 32'd0);
    checkOutput("rst_mem_write", 32'(mem_write), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
  endtask

  // Monitor: pops the scoreboard on every response and watches the memory strobes.
  always @(negedge clk) begin
    expect_t e;
    if (!rst) begin
      checkOutput("rw_exclusive", 32'(mem_read & mem_write), 32'd0);
      if (noMemAccess) checkOutput("fault_no_mem", 32'({mem_read, mem_write}), 32'd0);
      if (mem_read || mem_write) checkOutput("mem_addr", mem_addr, expMemAddr);
      if (resp_valid) begin
        lastRdata = resp_rdata;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_resp actual=resp_valid required=no response");
        end else begin
          e = expQ.pop_front();
          checkOutput("resp_rdata", resp_rdata, e.rdata);
          checkOutput("resp_err", 32'(resp_err), 32'(e.err));
        end
      end
    end
  end

  // Watchdog so a stuck handshake still reaches a verdict.
  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed cases from the datasheet, then randomized traffic, then reset mid-RMW.
  initial begin
    checks      = 0;
    errors      = 0;
    expMemAddr  = 32'h0;
    noMemAccess = 1'b0;
    lastRdata   = 32'h0;
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_size    = 2'b00;
    req_signed  = 1'b0;
    req_addr    = 32'h0;
    req_wdata   = 32'h0;
    repeat (2) @(negedge clk);
    checkResetValues();
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom, 1'b0);

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 1'b0);
    checkOutput("word_store_mem2", memArray[2], 32'hDEADBEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b0);
    checkOutput("word_load_08", lastRdata, 32'hDEADBEEF);

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h04, 32'h11223344, 1'b0);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h06, 32'h000000AA, 1'b0);
    checkOutput("byte_rmw_mem1", memArray[1], 32'h11AA3344);

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h00, 32'h80FF7F01, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h02, 32'h0, 1'b0);
    checkOutput("lb_2", lastRdata, 32'hFFFFFFFF);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h02, 32'h0, 1'b0);
    checkOutput("lbu_2", lastRdata, 32'h000000FF);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h02, 32'h0, 1'b0);
    checkOutput("lh_2", lastRdata, 32'hFFFF80FF);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h00, 32'h0, 1'b0);
    checkOutput("lhu_0", lastRdata, 32'h00007F01);

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b1);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h0A, 32'h0000CAFE, 1'b1);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0);
`endif

    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'($urandom), 2'($urandom), 1'($urandom),
                    32'($urandom_range(0, 63)), $urandom, 1'($urandom));
    end

    // Byte store to word 3, reset while the WRITE cycle is still before its falling edge.
    @(negedge clk);
    expMemAddr = 32'd3;
    req_write  = 1'b1;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h0D;
    req_wdata  = 32'h0000005A ^ {24'h0, refMem[3][15:8]};
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("in_write_before_reset", 32'(mem_write), 32'd1);
    rst = 1'b1;
    #1;
    checkResetValues();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checkOutput("no_resp_after_reset", 32'(resp_valid), 32'd0);
    end
    checkOutput("reset_mem3_unchanged", memArray[3], refMem[3]);

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 1'b0);

    for (int i = 0; i < DEPTH; i++) checkOutput("final_mem", memArray[i], refMem[i]);
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
